// File: rtl/npu_host_cmd_master_if.sv
// Host command, write/read data streams and NPU bus bundle for npu_host_cmd_master.
// The master modport is the initiator side; slave is the host/bus model side.
interface npu_host_cmd_master_if #(
   parameter int DWidth     = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_W      = 16
);
   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic [2:0]            cmd_op_i;
   logic [ADDR_WIDTH-1:0] cmd_offset_i;
   logic [LEN_W-1:0]      cmd_len_i;
   logic                  wr_valid_i;
   logic [DWidth-1:0]     wr_data_i;
   logic                  wr_ready_o;
   logic                  rd_valid_o;
   logic [DWidth-1:0]     rd_data_o;
   logic                  rd_ready_i;
   logic                  cen_o;
   logic                  wen_o;
   logic [ADDR_WIDTH-1:0] addr_o;
   logic [DWidth-1:0]     wdata_o;
   logic [DWidth-1:0]     rdata_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  err_o;

   modport master (
      input  cmd_valid_i, cmd_op_i, cmd_offset_i, cmd_len_i,
      input  wr_valid_i, wr_data_i, rd_ready_i, rdata_i,
      output cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o,
      output cen_o, wen_o, addr_o, wdata_o, busy_o, done_o, err_o
   );

   modport slave (
      output cmd_valid_i, cmd_op_i, cmd_offset_i, cmd_len_i,
      output wr_valid_i, wr_data_i, rd_ready_i, rdata_i,
      input  cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o,
      input  cen_o, wen_o, addr_o, wdata_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/npu_host_cmd_master.sv
// Host-side initiator for the NPU bus: expands one command into a burst of
// single-beat cen/wen/addr/wdata cycles, with a 2-entry buffer for read data.
module npu_host_cmd_master #(
   parameter int                    DWidth         = 8,
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    LEN_W          = 16,
   parameter logic [ADDR_WIDTH-1:0] NPU_IMEM_Start = 'h0000_1000,
   parameter logic [ADDR_WIDTH-1:0] NPU_IMEM_End   = 'h0000_2000,
   parameter logic [ADDR_WIDTH-1:0] NPU_WMEM_Start = 'h0001_0000,
   parameter logic [ADDR_WIDTH-1:0] NPU_WMEM_End   = 'h0001_8000,
   parameter logic [ADDR_WIDTH-1:0] NPU_BMEM_Start = 'h0002_0000,
   parameter logic [ADDR_WIDTH-1:0] NPU_BMEM_End   = 'h0002_0400,
   parameter logic [ADDR_WIDTH-1:0] NPU_OMEM_Start = 'h0003_0000,
   parameter logic [ADDR_WIDTH-1:0] NPU_OMEM_End   = 'h0003_0100,
   parameter logic [ADDR_WIDTH-1:0] NPU_OP_Start   = 'h0004_0000
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   npu_host_cmd_master_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_READ, S_DRAIN, S_TRIG, S_DONE
   } state_t;

   state_t                     state_q, state_d;
   logic [2:0]                 op_q, op_d;
   logic [ADDR_WIDTH-1:0]      base_q, base_d;
   logic [LEN_W-1:0]           len_q, len_d;
   logic [LEN_W-1:0]           cnt_q, cnt_d;
   logic                       cen_q, cen_d;
   logic                       wen_q, wen_d;
   logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
   logic [DWidth-1:0]          wdata_q, wdata_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       err_q, err_d;
   logic                       cmd_ready_q, cmd_ready_d;
   // [0]: read beat on the bus now, [1]: its rdata_i is valid now
   logic [1:0]                 rd_pipe_q, rd_pipe_d;
   logic [1:0][DWidth-1:0]     fifo_q, fifo_d;
   logic                       fifo_wp_q, fifo_wp_d;
   logic                       fifo_rp_q, fifo_rp_d;
   logic [1:0]                 fifo_cnt_q, fifo_cnt_d;

   logic [ADDR_WIDTH-1:0]      reg_start, reg_size;
   logic [ADDR_WIDTH:0]        span, len_ext;
   logic                       cmd_bad;
   logic                       fifo_push, fifo_pop;
   logic [2:0]                 occupancy;
   logic                       last_beat;
   logic                       wr_ready;

   always_comb begin
      reg_start = NPU_IMEM_Start;
      reg_size  = NPU_IMEM_End - NPU_IMEM_Start;
      case (bus.cmd_op_i)
         3'd1: begin
            reg_start = NPU_WMEM_Start;
            reg_size  = NPU_WMEM_End - NPU_WMEM_Start;
         end
         3'd2: begin
            reg_start = NPU_BMEM_Start;
            reg_size  = NPU_BMEM_End - NPU_BMEM_Start;
         end
         3'd3: begin
            reg_start = NPU_OMEM_Start;
            reg_size  = NPU_OMEM_End - NPU_OMEM_Start;
         end
         default: ;
      endcase
   end

   // One extra bit so an offset+len that overflows the address space is caught
   assign len_ext = {{(ADDR_WIDTH + 1 - LEN_W){1'b0}}, bus.cmd_len_i};
   assign span    = {1'b0, bus.cmd_offset_i} + len_ext;
   assign cmd_bad = (bus.cmd_op_i > 3'd5) ||
                    ((bus.cmd_op_i < 3'd4) &&
                     ((bus.cmd_len_i == '0) || (span > {1'b0, reg_size})));

   assign fifo_push = rd_pipe_q[1];
   assign fifo_pop  = (fifo_cnt_q != 2'd0) && bus.rd_ready_i;
   assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, rd_pipe_q[0]} + {2'b00, rd_pipe_q[1]};
   assign last_beat = (cnt_q == len_q - LEN_W'(1));

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      base_d    = base_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      cen_d     = 1'b0;
      wen_d     = wen_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = 1'b0;
      rd_pipe_d = {rd_pipe_q[0], 1'b0};
      wr_ready  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid_i && cmd_ready_q) begin
               op_d   = bus.cmd_op_i;
               base_d = reg_start + bus.cmd_offset_i;
               len_d  = bus.cmd_len_i;
               cnt_d  = '0;
               if (cmd_bad) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else if (bus.cmd_op_i < 3'd3) begin
                  state_d = S_WRITE;
               end else if (bus.cmd_op_i == 3'd3) begin
                  state_d = S_READ;
               end else begin
                  state_d = S_TRIG;
               end
            end
         end
         S_WRITE: begin
            if (bus.wr_valid_i) begin
               wr_ready = 1'b1;
               cen_d    = 1'b1;
               wen_d    = 1'b1;
               addr_d   = base_q + ADDR_WIDTH'(cnt_q);
               wdata_d  = bus.wr_data_i;
               cnt_d    = cnt_q + LEN_W'(1);
               if (last_beat) state_d = S_DONE;
            end
         end
         S_READ: begin
            // Count beats already in flight so a stalled reader never overflows the buffer
            if (occupancy < 3'd2) begin
               cen_d        = 1'b1;
               wen_d        = 1'b0;
               addr_d       = base_q + ADDR_WIDTH'(cnt_q);
               rd_pipe_d[0] = 1'b1;
               cnt_d        = cnt_q + LEN_W'(1);
               if (last_beat) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((rd_pipe_q == 2'b00) && (fifo_cnt_q == 2'd0)) state_d = S_DONE;
         end
         S_TRIG: begin
            cen_d   = 1'b1;
            wen_d   = 1'b1;
            addr_d  = (op_q == 3'd5) ? NPU_OP_Start + ADDR_WIDTH'(4) : NPU_OP_Start;
            wdata_d = DWidth'(1);
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      cmd_ready_d = (state_d == S_IDLE);
   end

   always_comb begin
      fifo_d     = fifo_q;
      fifo_wp_d  = fifo_wp_q;
      fifo_rp_d  = fifo_rp_q;
      fifo_cnt_d = fifo_cnt_q;
      if (fifo_push) begin
         fifo_d[fifo_wp_q] = bus.rdata_i;
         fifo_wp_d         = ~fifo_wp_q;
      end
      if (fifo_pop) fifo_rp_d = ~fifo_rp_q;
      case ({fifo_push, fifo_pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         base_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         cen_q       <= 1'b0;
         wen_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cmd_ready_q <= 1'b0;
         rd_pipe_q   <= '0;
         fifo_q      <= '0;
         fifo_wp_q   <= 1'b0;
         fifo_rp_q   <= 1'b0;
         fifo_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         base_q      <= base_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         cen_q       <= cen_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cmd_ready_q <= cmd_ready_d;
         rd_pipe_q   <= rd_pipe_d;
         fifo_q      <= fifo_d;
         fifo_wp_q   <= fifo_wp_d;
         fifo_rp_q   <= fifo_rp_d;
         fifo_cnt_q  <= fifo_cnt_d;
      end
   end

   assign bus.cmd_ready_o = cmd_ready_q;
   assign bus.wr_ready_o  = wr_ready;
   assign bus.rd_valid_o  = (fifo_cnt_q != 2'd0);
   assign bus.rd_data_o   = fifo_q[fifo_rp_q];
   assign bus.cen_o       = cen_q;
   assign bus.wen_o       = wen_q;
   assign bus.addr_o      = addr_q;
   assign bus.wdata_o     = wdata_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_npu_host_cmd_master.sv
// Directed bench for npu_host_cmd_master: writes, gapped writes, read with
// backpressure, triggers, rejected commands and reset in the middle of a burst.
module tb_npu_host_cmd_master;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   npu_host_cmd_master_if #(.DWidth(8), .ADDR_WIDTH(32), .LEN_W(16)) bus_if ();

   npu_host_cmd_master dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [7:0]  wdata;
   } beat_t;

   beat_t      beats[$];
   logic [7:0] rd_q[$];
   logic [7:0] wb[8];
   int         done_cnt = 0;
   logic       last_err = 1'b0;
   logic       rd_tog   = 1'b0;

   // Bus slave: read data is addr[7:0]^A5, presented the cycle after the read beat
   always @(posedge clk)
      bus_if.rdata_i <= (bus_if.cen_o && !bus_if.wen_o) ? (bus_if.addr_o[7:0] ^ 8'hA5) : 8'h00;

   always @(negedge clk) begin
      if (rd_tog) bus_if.rd_ready_i = ~bus_if.rd_ready_i;
      #1;
      if (rst_n) begin
         if (bus_if.cen_o) beats.push_back({bus_if.wen_o, bus_if.addr_o, bus_if.wdata_o});
         if (bus_if.rd_valid_o && bus_if.rd_ready_i) rd_q.push_back(bus_if.rd_data_o);
         if (bus_if.done_o) begin
            done_cnt++;
            last_err = bus_if.err_o;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] off, input logic [15:0] len);
      int g = 0;
      beats.delete();
      bus_if.cmd_op_i     = op;
      bus_if.cmd_offset_i = off;
      bus_if.cmd_len_i    = len;
      bus_if.cmd_valid_i  = 1'b1;
      #1;
      while (!bus_if.cmd_ready_o && g < 50) begin
         @(negedge clk); #1; g++;
      end
      @(negedge clk);
      bus_if.cmd_valid_i = 1'b0;
      check("cmd_accept_in_time", 64'(g < 50), 64'd1);
   endtask

   task automatic send_wr(input int n, input int gap_at);
      int i = 0, g = 0, guard = 0;
      while (i < n && guard < 100) begin
         if (i == gap_at && g < 2) begin
            bus_if.wr_valid_i = 1'b0;
            g++;
         end else begin
            bus_if.wr_valid_i = 1'b1;
            bus_if.wr_data_i  = wb[i];
            #1;
            if (bus_if.wr_ready_o) i++;
         end
         @(negedge clk);
         guard++;
      end
      bus_if.wr_valid_i = 1'b0;
      check("wr_stream_in_time", 64'(guard < 100), 64'd1);
   endtask

   task automatic wait_done(input string tag);
      int g = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && g < 300) begin
         @(negedge clk); #2; g++;
      end
      check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic check_beat(input string tag, input int k, input logic wen,
                             input logic [31:0] addr, input logic [7:0] wd, input logic chk_wd);
      beat_t b;
      b = (k < beats.size()) ? beats[k] : '0;
      check({tag, "_wen"},  64'(b.wen),  64'(wen));
      check({tag, "_addr"}, 64'(b.addr), 64'(addr));
      if (chk_wd) check({tag, "_wdata"}, 64'(b.wdata), 64'(wd));
   endtask

   initial begin
      int d0, g;
      logic [7:0] exp_rd[5];
      rst_n               = 1'b0;
      bus_if.cmd_valid_i  = 1'b0;
      bus_if.cmd_op_i     = '0;
      bus_if.cmd_offset_i = '0;
      bus_if.cmd_len_i    = '0;
      bus_if.wr_valid_i   = 1'b0;
      bus_if.wr_data_i    = '0;
      bus_if.rd_ready_i   = 1'b1;

      // reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_cen",       64'(bus_if.cen_o),       64'd0);
      check("rst_wen",       64'(bus_if.wen_o),       64'd0);
      check("rst_addr",      64'(bus_if.addr_o),      64'd0);
      check("rst_wdata",     64'(bus_if.wdata_o),     64'd0);
      check("rst_rd_valid",  64'(bus_if.rd_valid_o),  64'd0);
      check("rst_busy",      64'(bus_if.busy_o),      64'd0);
      check("rst_done",      64'(bus_if.done_o),      64'd0);
      check("rst_err",       64'(bus_if.err_o),       64'd0);
      check("rst_cmd_ready", 64'(bus_if.cmd_ready_o), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk); #1;
      check("post_rst_cmd_ready", 64'(bus_if.cmd_ready_o), 64'd1);

      // IMEM load, back-to-back bytes
      wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33; wb[3] = 8'h44;
      @(negedge clk);
      issue(3'd0, 32'd0, 16'd4);
      check("imem_busy", 64'(bus_if.busy_o), 64'd1);
      send_wr(4, -1);
      wait_done("imem");
      check("imem_err",   64'(last_err), 64'd0);
      check("imem_beats", 64'(beats.size()), 64'd4);
      check_beat("imem_b0", 0, 1'b1, 32'h0000_1000, 8'h11, 1'b1);
      check_beat("imem_b1", 1, 1'b1, 32'h0000_1001, 8'h22, 1'b1);
      check_beat("imem_b2", 2, 1'b1, 32'h0000_1002, 8'h33, 1'b1);
      check_beat("imem_b3", 3, 1'b1, 32'h0000_1003, 8'h44, 1'b1);
      @(negedge clk); #1;
      check("imem_busy_clear", 64'(bus_if.busy_o), 64'd0);

      // WMEM with a 2-cycle gap before beat 1
      wb[0] = 8'hA0; wb[1] = 8'hA1; wb[2] = 8'hA2;
      issue(3'd1, 32'd8, 16'd3);
      send_wr(3, 1);
      wait_done("wmem");
      check("wmem_err",   64'(last_err), 64'd0);
      check("wmem_beats", 64'(beats.size()), 64'd3);
      check_beat("wmem_b0", 0, 1'b1, 32'h0001_0008, 8'hA0, 1'b1);
      check_beat("wmem_b1", 1, 1'b1, 32'h0001_0009, 8'hA1, 1'b1);
      check_beat("wmem_b2", 2, 1'b1, 32'h0001_000A, 8'hA2, 1'b1);

      // OMEM read, off=0x10 len=5 with rd_ready toggling
      exp_rd[0] = 8'hB5; exp_rd[1] = 8'hB4; exp_rd[2] = 8'hB7;
      exp_rd[3] = 8'hB6; exp_rd[4] = 8'hB1;
      rd_q.delete();
      rd_tog = 1'b1;
      issue(3'd3, 32'h10, 16'd5);
      wait_done("omem");
      rd_tog = 1'b0;
      bus_if.rd_ready_i = 1'b1;
      check("omem_err",      64'(last_err), 64'd0);
      check("omem_beats",    64'(beats.size()), 64'd5);
      check_beat("omem_b0", 0, 1'b0, 32'h0003_0010, 8'h00, 1'b0);
      check_beat("omem_b4", 4, 1'b0, 32'h0003_0014, 8'h00, 1'b0);
      check("omem_rd_count", 64'(rd_q.size()), 64'd5);
      for (int k = 0; k < 5; k++)
         check($sformatf("omem_rd%0d", k), 64'((k < rd_q.size()) ? rd_q[k] : 8'h00), 64'(exp_rd[k]));
      check("omem_rd_valid_idle", 64'(bus_if.rd_valid_o), 64'd0);

      // triggers
      issue(3'd4, 32'd0, 16'd0);
      wait_done("os_trig");
      check("os_trig_err",   64'(last_err), 64'd0);
      check("os_trig_beats", 64'(beats.size()), 64'd1);
      check_beat("os_trig", 0, 1'b1, 32'h0004_0000, 8'h01, 1'b1);
      issue(3'd5, 32'd0, 16'd0);
      wait_done("dm_trig");
      check("dm_trig_beats", 64'(beats.size()), 64'd1);
      check_beat("dm_trig", 0, 1'b1, 32'h0004_0004, 8'h01, 1'b1);

      // rejected commands
      issue(3'd7, 32'd0, 16'd1);
      wait_done("err_op7");
      check("err_op7_err",  64'(last_err), 64'd1);
      check("err_op7_cen",  64'(beats.size()), 64'd0);
      issue(3'd0, 32'd0, 16'd0);
      wait_done("err_len0");
      check("err_len0_err", 64'(last_err), 64'd1);
      check("err_len0_cen", 64'(beats.size()), 64'd0);
      issue(3'd2, 32'h3FF, 16'd2);
      wait_done("err_range");
      check("err_range_err", 64'(last_err), 64'd1);
      check("err_range_cen", 64'(beats.size()), 64'd0);
      // exactly at the region end is legal
      wb[0] = 8'h77;
      issue(3'd2, 32'h3FF, 16'd1);
      send_wr(1, -1);
      wait_done("bmem_edge");
      check("bmem_edge_err", 64'(last_err), 64'd0);
      check_beat("bmem_edge", 0, 1'b1, 32'h0002_03FF, 8'h77, 1'b1);

      // reset during beat 2 of an 8-beat load
      issue(3'd0, 32'd0, 16'd8);
      bus_if.wr_valid_i = 1'b1;
      bus_if.wr_data_i  = 8'h5A;
      g = 0;
      while (beats.size() < 2 && g < 50) begin
         @(negedge clk); #2; g++;
      end
      check("rstmid_reached_beat2", 64'(g < 50), 64'd1);
      check("rstmid_cen_before", 64'(bus_if.cen_o), 64'd1);
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check("rstmid_cen",  64'(bus_if.cen_o),  64'd0);
      check("rstmid_busy", 64'(bus_if.busy_o), 64'd0);
      bus_if.wr_valid_i = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk); #2;
      check("rstmid_cmd_ready", 64'(bus_if.cmd_ready_o), 64'd1);
      check("rstmid_no_done",   64'(done_cnt - d0), 64'd0);
      issue(3'd4, 32'd0, 16'd0);
      wait_done("rstmid_trig");
      check_beat("rstmid_trig", 0, 1'b1, 32'h0004_0000, 8'h01, 1'b1);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
